// File: rtl/display_arbiter_if.sv
// rtl/display_arbiter_if.sv - request/grant and display-word bundle between producers and display_arbiter
interface display_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    localparam int OW = $clog2(N);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       grant;
    logic [OW-1:0]      owner;
    logic [WIDTH-1:0]   disp_data;
    logic               disp_valid;

    // Producer side: raises requests and supplies words, observes who owns the display
    modport master (
        output req, req_data,
        input  grant, owner, disp_data, disp_valid
    );

    // Arbiter side
    modport slave (
        input  req, req_data,
        output grant, owner, disp_data, disp_valid
    );
endinterface

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin display arbiter with minimum hold; DISPLAY_ARB_PRIORITY_EN selects fixed priority
module display_arbiter #(
    parameter int N           = 4,
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    display_arbiter_if.slave bus
);
    localparam int OW = $clog2(N);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [OW-1:0] OWNER_RST = OW'(N - 1);
    localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]    state;
    logic [HW-1:0] hold_cnt;
    logic          hold_expired;
    logic [N-1:0]  cand;
    logic          win_found;
    logic [OW-1:0] win_idx;

    assign hold_expired = (hold_cnt == HOLD_MAX);

    // Requesters eligible to win: all of them when idle, only challengers while held
    always_comb begin
        cand = bus.req;
        if (state == S_HELD) begin
`ifdef DISPLAY_ARB_PRIORITY_EN
            // only a strictly lower index may take the display away
            for (int i = 0; i < N; i++) begin
                if (i >= int'(bus.owner)) cand[i] = 1'b0;
            end
`else
            cand[bus.owner] = 1'b0;
`endif
        end
    end

    // Winner among the eligible requesters
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef DISPLAY_ARB_PRIORITY_EN
        // descending scan so the lowest active index is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_found = 1'b1;
                win_idx   = OW'(i);
            end
        end
`else
        // descending distance from owner so the nearest one after owner is kept
        for (int d = N; d >= 1; d--) begin
            if (cand[(int'(bus.owner) + d) % N]) begin
                win_found = 1'b1;
                win_idx   = OW'((int'(bus.owner) + d) % N);
            end
        end
`endif
    end

    // Grant state, hold timer and registered display word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            hold_cnt       <= '0;
            bus.grant      <= '0;
            bus.owner      <= OWNER_RST;
            bus.disp_data  <= '0;
            bus.disp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state          <= S_HELD;
                        hold_cnt       <= '0;
                        bus.grant      <= ONE_HOT0 << win_idx;
                        bus.owner      <= win_idx;
                        bus.disp_data  <= bus.req_data[win_idx*WIDTH +: WIDTH];
                        bus.disp_valid <= 1'b1;
                    end
                end
                default: begin
                    if (!bus.req[bus.owner]) begin
                        // owner let go; disp_data keeps its last word
                        state          <= S_IDLE;
                        hold_cnt       <= '0;
                        bus.grant      <= '0;
                        bus.disp_valid <= 1'b0;
                    end else if (hold_expired && win_found) begin
                        // hand over directly, no idle gap
                        hold_cnt       <= '0;
                        bus.grant      <= ONE_HOT0 << win_idx;
                        bus.owner      <= win_idx;
                        bus.disp_data  <= bus.req_data[win_idx*WIDTH +: WIDTH];
                    end else begin
                        if (!hold_expired) hold_cnt <= hold_cnt + 1'b1;
                        bus.disp_data <= bus.req_data[bus.owner*WIDTH +: WIDTH];
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - self-checking bench for display_arbiter (N=4, WIDTH=16, HOLD_CYCLES=4)
module tb_display_arbiter;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    display_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    display_arbiter #(.N(N), .WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_owner;
        logic        exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    // Reference model: who holds the display, for how long, and what it shows
    bit          m_held;
    int          m_owner;
    int          m_age;
    logic [15:0] m_data;

    function automatic logic [15:0] slice_of(logic [63:0] d, int i);
        return d[i*16 +: 16];
    endfunction

    // Returns the requester to grant next, or -1; challenger excludes the holder
    function automatic int choose(logic [3:0] r, int last, bit challenger);
        int best  = -1;
        int bestd = 1000;
        for (int i = 0; i < N; i++) begin
            int d;
            if (!r[i]) continue;
`ifdef DISPLAY_ARB_PRIORITY_EN
            if (challenger && i >= last) continue;
            d = i;
`else
            if (challenger && i == last) continue;
            d = (i - last - 1 + N) % N;
`endif
            if (d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_held  = 0;
        m_owner = N - 1;
        m_age   = 0;
        m_data  = '0;
    endtask

    task automatic model_step(logic [3:0] r, logic [63:0] d);
        int w;
        if (!m_held) begin
            w = choose(r, m_owner, 0);
            if (w >= 0) begin
                m_held = 1; m_owner = w; m_age = 0; m_data = slice_of(d, w);
            end
        end else if (!r[m_owner]) begin
            m_held = 0;
        end else begin
            w = (m_age >= HOLD) ? choose(r, m_owner, 1) : -1;
            if (w >= 0) begin
                m_owner = w; m_age = 0; m_data = slice_of(d, w);
            end else begin
                m_age  = (m_age + 1 > HOLD) ? HOLD : m_age + 1;
                m_data = slice_of(d, m_owner);
            end
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(bus.req, bus.req_data);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        bus.req      = '0;
        bus.req_data = '0;

        vecs[0] = '{4'b0100, 64'h0000_BEEF_0000_0000, 4'b0100, 2'd2, 1'b1, 16'hBEEF};
        vecs[1] = '{4'b0100, 64'h0000_1234_0000_0000, 4'b0100, 2'd2, 1'b1, 16'h1234};
        vecs[2] = '{4'b0000, 64'h0000_1234_0000_0000, 4'b0000, 2'd2, 1'b0, 16'h1234};
        vecs[3] = '{4'b0001, 64'h0000_0000_0000_AAAA, 4'b0001, 2'd0, 1'b1, 16'hAAAA};
        vecs[4] = '{4'b0011, 64'h0000_0000_5555_AAAA, 4'b0001, 2'd0, 1'b1, 16'hAAAA};
        vecs[5] = '{4'b0010, 64'h0000_0000_5555_AAAA, 4'b0000, 2'd0, 1'b0, 16'hAAAA};
        vecs[6] = '{4'b0010, 64'h0000_0000_5555_AAAA, 4'b0010, 2'd1, 1'b1, 16'h5555};

        do_reset();
        chk("reset_grant", bus.grant, 0);
        chk("reset_owner", bus.owner, 3);
        chk("reset_valid", bus.disp_valid, 0);
        chk("reset_data",  bus.disp_data, 0);

        for (int i = 0; i < 7; i++) begin
            bus.req      = vecs[i].req;
            bus.req_data = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_grant", i), bus.grant,      vecs[i].exp_grant);
            chk($sformatf("vec%0d_owner", i), bus.owner,      vecs[i].exp_owner);
            chk($sformatf("vec%0d_valid", i), bus.disp_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_data",  i), bus.disp_data,  vecs[i].exp_data);
        end

        // asynchronous reset in the middle of a grant, between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", bus.grant, 0);
        chk("async_rst_owner", bus.owner, 3);
        chk("async_rst_valid", bus.disp_valid, 0);
        chk("async_rst_data",  bus.disp_data, 0);
        bus.req = '0;
        do_reset();

        // all four request continuously
        bus.req      = 4'b1111;
        bus.req_data = 64'h4444_3333_2222_1111;
        for (int t = 0; t < 25; t++) begin
            tick();
`ifdef DISPLAY_ARB_PRIORITY_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'b0001 << ((t / 5) % 4);
`endif
            chk($sformatf("rotate_t%0d_grant", t), bus.grant, exp_g);
            chk($sformatf("rotate_t%0d_valid", t), bus.disp_valid, 1);
        end

        // early release with another requester waiting: one idle cycle
        bus.req = '0;
        do_reset();
        bus.req = 4'b0010;
        tick();
        chk("release_first_grant", bus.grant, 4'b0010);
        bus.req = 4'b1010;
        tick();
        tick();
        bus.req = 4'b1000;
        tick();
        chk("release_gap_grant", bus.grant, 4'b0000);
        chk("release_gap_valid", bus.disp_valid, 0);
        tick();
        chk("release_next_grant", bus.grant, 4'b1000);
        chk("release_next_owner", bus.owner, 3);

        // lone requester keeps the display; live data follows
        bus.req = '0;
        do_reset();
        bus.req      = 4'b0100;
        bus.req_data = 64'h0000_0001_0000_0000;
        for (int t = 0; t < 20; t++) begin
            tick();
            chk($sformatf("lone_t%0d_grant", t), bus.grant, 4'b0100);
        end
        chk("lone_data1", bus.disp_data, 16'h0001);
        bus.req_data = 64'h0000_0002_0000_0000;
        tick();
        chk("lone_data2", bus.disp_data, 16'h0002);
        bus.req = '0;
        tick();
        chk("drop_valid", bus.disp_valid, 0);
        chk("drop_data",  bus.disp_data, 16'h0002);
        bus.req = 4'b0001;
        tick();
        chk("new_req0_grant", bus.grant, 4'b0001);

`ifdef DISPLAY_ARB_PRIORITY_EN
        // a lower index takes over only once the hold has expired
        bus.req = '0;
        do_reset();
        bus.req = 4'b1000;
        tick();
        bus.req = 4'b1010;
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk($sformatf("prio_hold_t%0d", t), bus.grant, 4'b1000);
        end
        tick();
        chk("prio_preempt", bus.grant, 4'b0010);
`endif

        // randomized traffic against the model
        bus.req = '0;
        do_reset();
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            bus.req_data[($urandom_range(0, 3))*16 +: 16] = 16'($urandom);
            tick();
            chk($sformatf("rand_t%0d_grant", t), bus.grant, m_held ? (4'b0001 << m_owner) : 4'b0000);
            chk($sformatf("rand_t%0d_owner", t), bus.owner, m_owner);
            chk($sformatf("rand_t%0d_valid", t), bus.disp_valid, m_held);
            chk($sformatf("rand_t%0d_data",  t), bus.disp_data, m_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit seven-segment display resource between up to N requesters, such as a slow counter, DIP-switch echo or debug word. Uses a registered request/grant handshake with round-robin arbitration and a minimum-hold timer so the display does not flicker between sources. It sits between the data producers and `binary2display`, driving that block's 16-bit `data` input, and reports which source currently owns the display.

## Interface
- `N`, 4: number of requesters, 2..8.
- `WIDTH`, 16: display word width per requester (4 hex digits).
- `HOLD_CYCLES`, 100_000_000: minimum grant duration before preemption (1 s at 100 MHz); must be ≥ 1.

- `clk`  in  1  100 MHz system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester display request, level-sensitive.
- `req_data`  in  N*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- `grant`  out  N  one-hot grant; all-zero when idle.
- `owner`  out  $clog2(N)  index of the current/last owner.
- `disp_data`  out  WIDTH  word to `binary2display`.
- `disp_valid`  out  1  high while some requester holds a grant.

## Operation
- Two states: IDLE and HELD.
- Hold counter `hold_cnt` is $clog2(HOLD_CYCLES+1) bits wide. It saturates at HOLD_CYCLES, and the hold is expired when `hold_cnt` == HOLD_CYCLES.

IDLE:
- If `req` != 0, select a winner by round-robin: search starts at `owner`+1 mod N and wraps. Lowest distance wins.
- Next state is HELD, with `grant` set one-hot to the winner, `owner` set to the winner, and `hold_cnt` set to 0.
- Otherwise stay in IDLE.

HELD:
- `hold_cnt` increments each cycle until it saturates.
- If `req[owner]` = 0: release. Next state is IDLE and `grant` becomes 0. Release is allowed at any time, including before the hold expires.
- Else, if the hold is expired and another requester is active: preempt. Go directly to HELD with the round-robin winner, excluding the current owner, and reset `hold_cnt` to 0. There is no idle gap.
- Else: stay in HELD.

Data path:
- While in HELD, `disp_data` is registered from the owner's slice every cycle, so live updates pass through.
- In IDLE, `disp_data` holds its last value and `disp_valid` = 0.

Boundary cases:
- A release and a new request in the same cycle go to IDLE. The new requester is granted on the following edge, giving a 1-cycle gap.
- If only the owner requests after hold expiry, it keeps the grant indefinitely.
- All requesters asserting at once from reset: requester 0 wins first (`owner` resets to N-1), then 1, 2, …
- If `req` deasserts during IDLE arbitration, only `req` sampled at the edge counts.
- Reset asserted mid-grant clears all state immediately (asynchronously).

## Timing
- Reset values:
  - state = IDLE
  - `grant` = 0
  - `owner` = N-1
  - `disp_data` = 0
  - `disp_valid` = 0
  - `hold_cnt` = 0
- Request to grant latency: 1 cycle. `req` sampled high at edge k gives `grant` high after edge k.
- `disp_data` and `disp_valid` are valid in the same cycle as `grant`.
- Data update latency while held: 1 cycle from `req_data` to `disp_data`.
- Release latency: 1 cycle from `req[owner]` low to `grant` low.
- Earliest preemption: `grant` changes on the edge HOLD_CYCLES+1 cycles after the grant was issued.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `DISPLAY_ARB_PRIORITY_EN` defined: fixed priority replaces round-robin. The lowest active index wins in both IDLE and preemption.
  - Preemption occurs only when a lower-index requester is active after hold expiry.
  - Higher-index requesters never preempt.
- Undefined (default): round-robin as described above.

## Test plan
Bench parameters: N=4, WIDTH=16, HOLD_CYCLES=4.
- Reset then `req`=4'b0100 with slice 2 = 16'hBEEF → `grant`=4'b0100, `owner`=2, `disp_data`=16'hBEEF, `disp_valid`=1 one cycle after `req`. Assert `rst_n`=0 mid-grant → all outputs 0 and `owner`=3 immediately.
- `req`=4'b1111 held continuously → grants 0,1,2,3,0 in turn. Each grant lasts exactly 5 cycles, with no idle cycles between them.
- Owner 1 drops `req` after 2 cycles while `req[3]`=1 → `grant`=0 for 1 cycle, then `grant`=4'b1000.
- Only requester 2 active for 20 cycles → `grant` stays 4'b0100 throughout. Changing slice 2 from 16'h0001 to 16'h0002 appears on `disp_data` 1 cycle later.
- All requests drop → `disp_valid`=0 while `disp_data` retains the last word. A new `req[0]` → `grant`=4'b0001.
- With `DISPLAY_ARB_PRIORITY_EN` defined: `req`=4'b1111 → `grant` stays 4'b0001 indefinitely. Owner 3 holding, then `req[1]` rises → `grant` switches to 4'b0010 at hold expiry.
